// File: rtl/pulse_train_gen.sv
// Programmable pulse-train / burst generator feeding the frequency counter input.
// Period, high time and pulse count are taken over a valid/ready config port while idle.
module pulse_train_gen #(
  parameter int WIDTH      = 32,
  parameter int DEF_PERIOD = 10
) (
  input  logic             clock,
  input  logic             reset,
  // Handshake: a config word transfers on a clock edge where cfg_valid & cfg_ready
  // are both 1. cfg_ready is 1 only in IDLE. cfg_valid must be held until that edge,
  // and a word offered while busy is neither consumed nor checked.
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [WIDTH-1:0] cfg_count,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             signal_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulses_sent,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_PERIOD / 2);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  state_t           state, state_n;
  logic [WIDTH-1:0] ph, ph_n;
  logic [WIDTH-1:0] period_q, period_n;
  logic [WIDTH-1:0] high_q, high_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] pulses_q, pulses_n;
  logic             sig_q, sig_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic             stop_pend, stop_pend_n;

  logic             cfg_legal;
  logic [WIDTH-1:0] low_len;
  logic             last_pulse;

  assign cfg_legal  = (cfg_period >= TWO) && (cfg_high != '0) && (cfg_high < cfg_period);
  assign low_len    = period_q - high_q;
  assign last_pulse = (count_q != '0) && (pulses_q == count_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ph        <= '0;
      period_q  <= DEF_P;
      high_q    <= DEF_H;
      count_q   <= '0;
      pulses_q  <= '0;
      sig_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      period_q  <= period_n;
      high_q    <= high_n;
      count_q   <= count_n;
      pulses_q  <= pulses_n;
      sig_q     <= sig_n;
      done_q    <= done_n;
      err_q     <= err_n;
      stop_pend <= stop_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    ph_n        = ph;
    period_n    = period_q;
    high_n      = high_q;
    count_n     = count_q;
    pulses_n    = pulses_q;
    sig_n       = sig_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    stop_pend_n = stop_pend;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            period_n = cfg_period;
            high_n   = cfg_high;
            count_n  = cfg_count;
          end else begin
            err_n = 1'b1;
          end
        end
        // Phase compares read the registers next cycle, so a same-edge config is used.
        if (start) begin
          state_n     = S_HIGH;
          sig_n       = 1'b1;
          ph_n        = ONE;
          pulses_n    = ONE;
          stop_pend_n = 1'b0;
        end
      end
      S_HIGH: begin
        stop_pend_n = stop_pend | stop;
        if (ph == high_q) begin
          state_n = S_LOW;
          sig_n   = 1'b0;
          ph_n    = ONE;
        end else begin
          ph_n = ph + ONE;
        end
      end
      S_LOW: begin
        if (ph == low_len) begin
          // Period boundary: a stop seen on this very edge also ends the run here.
          if (last_pulse || stop_pend || stop) begin
            state_n     = S_IDLE;
            sig_n       = 1'b0;
            ph_n        = '0;
            done_n      = 1'b1;
            stop_pend_n = 1'b0;
          end else begin
            state_n = S_HIGH;
            sig_n   = 1'b1;
            ph_n    = ONE;
            if (pulses_q != '1) begin
              pulses_n = pulses_q + ONE;
            end
          end
        end else begin
          ph_n        = ph + ONE;
          stop_pend_n = stop_pend | stop;
        end
      end
      default: begin
        state_n = S_IDLE;
        sig_n   = 1'b0;
        ph_n    = '0;
      end
    endcase
  end

  assign cfg_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign signal_out  = sig_q;
  assign done        = done_q;
  assign cfg_err     = err_q;
  assign pulses_sent = pulses_q;
  assign state_dbg   = state;

endmodule
